tdm_demux4x1: RTL and testbench

//  Receive end of the 4-channel word multiplexer: takes a time-division stream of

---
 rtl/tdm_demux_pkg.sv | 19 +
 rtl/tdm_slot_ctr.sv | 36 +++
 rtl/tdm_demux4x1.sv | 145 ++++++++++++++
 tb/tb_tdm_demux4x1.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tdm_demux_pkg
// Brief   : Shared types and constants for the 4-channel TDM word demultiplexer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package tdm_demux_pkg;

   localparam int         SLOT_W    = 2;
   localparam int         NUM_CH    = 4;
   localparam logic [1:0] SLOT_LAST = 2'd3;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } demux_state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tdm_slot_ctr
// Brief   : 2-bit slot index counter with clear, load-to-1 and increment.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tdm_slot_ctr
   import tdm_demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load1,
   input  logic              inc,
   output logic [SLOT_W-1:0] slot
);

   logic [SLOT_W-1:0] r_slot;

   // Clear wins over load so a parity abort on a sof word lands in slot 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= '0;
      end else if (clr) begin
         r_slot <= '0;
      end else if (load1) begin
         r_slot <= SLOT_W'(1);
      end else if (inc) begin
         r_slot <= r_slot + SLOT_W'(1);
      end
   end

   assign slot = r_slot;

endmodule
`default_nettype wire

// File: rtl/tdm_demux4x1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tdm_demux4x1
// Brief   : Rebuilds four parallel channels from a sof-marked TDM word stream.
//           Optional din_par parity check enabled by defining DEMUX_PARITY_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tdm_demux4x1
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  din,
   input  logic              din_valid,
   input  logic              sof,
`ifdef DEMUX_PARITY_EN
   input  logic              din_par,
`endif
   output logic [WIDTH-1:0]  y0,
   output logic [WIDTH-1:0]  y1,
   output logic [WIDTH-1:0]  y2,
   output logic [WIDTH-1:0]  y3,
   output logic              frame_valid,
   output logic              frame_err,
   output logic [SLOT_W-1:0] slot
);

   demux_state_t      r_state, w_state_nxt;
   logic [WIDTH-1:0]  r_stage0, r_stage1, r_stage2;
   logic [WIDTH-1:0]  r_y0, r_y1, r_y2, r_y3;
   logic              r_frame_valid, r_frame_err;
   logic              w_load1, w_inc, w_clr, w_err, w_done;
   logic              w_par_bad;
   logic [SLOT_W-1:0] w_slot;

`ifdef DEMUX_PARITY_EN
   // Even parity: din_par must equal the XOR of the word bits.
   assign w_par_bad = din_par ^ (^din);
`else
   assign w_par_bad = 1'b0;
`endif

   tdm_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .load1 (w_load1),
      .inc   (w_inc),
      .slot  (w_slot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load1     = 1'b0;
      w_inc       = 1'b0;
      w_clr       = 1'b0;
      w_err       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (din_valid) begin
               if (!w_par_bad && sof) begin
                  w_load1     = 1'b1;
                  w_state_nxt = COLLECT;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (din_valid) begin
               if (w_par_bad) begin
                  w_err       = 1'b1;
                  w_clr       = 1'b1;
                  w_state_nxt = IDLE;
               end else if (sof) begin
                  // Early sof restarts the frame with this word as slot 0.
                  w_err   = 1'b1;
                  w_load1 = 1'b1;
               end else if (w_slot == SLOT_LAST) begin
                  w_done      = 1'b1;
                  w_clr       = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_inc = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage0      <= '0;
         r_stage1      <= '0;
         r_stage2      <= '0;
         r_y0          <= '0;
         r_y1          <= '0;
         r_y2          <= '0;
         r_y3          <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_frame_valid <= w_done;
         r_frame_err   <= w_err;
         if (w_load1) begin
            r_stage0 <= din;
         end else if (w_inc) begin
            if (w_slot == SLOT_W'(1)) begin
               r_stage1 <= din;
            end else begin
               r_stage2 <= din;
            end
         end
         // All four outputs load together on the slot-3 word.
         if (w_done) begin
            r_y0 <= r_stage0;
            r_y1 <= r_stage1;
            r_y2 <= r_stage2;
            r_y3 <= din;
         end
      end
   end

   assign y0          = r_y0;
   assign y1          = r_y1;
   assign y2          = r_y2;
   assign y3          = r_y3;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign slot        = w_slot;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4x1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_tdm_demux4x1
// Brief   : Directed self-checking bench for tdm_demux4x1 (DEMUX_PARITY_EN aware).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_tdm_demux4x1;

   logic       clk;
   logic       rst_n;
   logic [3:0] din;
   logic       din_valid;
   logic       sof;
   logic       din_par;
   logic [3:0] y0, y1, y2, y3;
   logic       frame_valid;
   logic       frame_err;
   logic [1:0] slot;

   int checks = 0;
   int errors = 0;

   tdm_demux4x1 #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sof         (sof),
`ifdef DEMUX_PARITY_EN
      .din_par     (din_par),
`endif
      .y0          (y0),
      .y1          (y1),
      .y2          (y2),
      .y3          (y3),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .slot        (slot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stream input, then sample 1 time unit after the edge.
   task automatic send(input logic [3:0] w, input logic s, input logic v, input logic bad);
      @(negedge clk);
      din       = w;
      sof       = s;
      din_valid = v;
      din_par   = (^w) ^ bad;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      send(4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0; din_par = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_y",   {y0, y1, y2, y3}, 16'h0000);
      chk("rst_fv",  16'(frame_valid), 16'd0);
      chk("rst_fe",  16'(frame_err),   16'd0);
      chk("rst_slot", 16'(slot),       16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: back-to-back frame
      send(4'h1, 1'b1, 1'b1, 1'b0);
      chk("t1_slot1", 16'(slot), 16'd1);
      send(4'h2, 1'b0, 1'b1, 1'b0);
      send(4'h3, 1'b0, 1'b1, 1'b0);
      chk("t1_slot3", 16'(slot), 16'd3);
      chk("t1_yhold", {y0, y1, y2, y3}, 16'h0000);
      send(4'h4, 1'b0, 1'b1, 1'b0);
      chk("t1_y",    {y0, y1, y2, y3}, 16'h1234);
      chk("t1_fv",   16'(frame_valid), 16'd1);
      chk("t1_slot0", 16'(slot), 16'd0);
      idle();
      chk("t1_fv_pulse", 16'(frame_valid), 16'd0);

      // 2: gaps inside a frame
      send(4'h8, 1'b1, 1'b1, 1'b0);
      send(4'h9, 1'b0, 1'b1, 1'b0);
      idle(); idle(); idle();
      chk("t2_slot_gap", 16'(slot), 16'd2);
      chk("t2_yhold",    {y0, y1, y2, y3}, 16'h1234);
      chk("t2_fv_gap",   16'(frame_valid), 16'd0);
      send(4'hA, 1'b0, 1'b1, 1'b0);
      send(4'hB, 1'b0, 1'b1, 1'b0);
      chk("t2_y",  {y0, y1, y2, y3}, 16'h89AB);
      chk("t2_fv", 16'(frame_valid), 16'd1);

      // 3: early sof discards partial frame
      send(4'hA, 1'b1, 1'b1, 1'b0);
      chk("t3_fv_clr", 16'(frame_valid), 16'd0);
      send(4'hB, 1'b0, 1'b1, 1'b0);
      chk("t3_fe_none", 16'(frame_err), 16'd0);
      send(4'h5, 1'b1, 1'b1, 1'b0);
      chk("t3_fe",    16'(frame_err), 16'd1);
      chk("t3_slot1", 16'(slot), 16'd1);
      chk("t3_yhold", {y0, y1, y2, y3}, 16'h89AB);
      send(4'h6, 1'b0, 1'b1, 1'b0);
      chk("t3_fe_pulse", 16'(frame_err), 16'd0);
      send(4'h7, 1'b0, 1'b1, 1'b0);
      send(4'h8, 1'b0, 1'b1, 1'b0);
      chk("t3_y",  {y0, y1, y2, y3}, 16'h5678);
      chk("t3_fv", 16'(frame_valid), 16'd1);
      chk("t3_fe_end", 16'(frame_err), 16'd0);

      // 4: stray word in IDLE
      send(4'hF, 1'b0, 1'b1, 1'b0);
      chk("t4_fe",   16'(frame_err), 16'd1);
      chk("t4_fv",   16'(frame_valid), 16'd0);
      chk("t4_y",    {y0, y1, y2, y3}, 16'h5678);
      chk("t4_slot", 16'(slot), 16'd0);
      idle();
      chk("t4_fe_pulse", 16'(frame_err), 16'd0);

      // 5: asynchronous reset mid-frame
      send(4'h9, 1'b1, 1'b1, 1'b0);
      send(4'h1, 1'b0, 1'b1, 1'b0);
      chk("t5_slot_pre", 16'(slot), 16'd2);
      @(negedge clk);
      din_valid = 1'b0;
      sof       = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_y_async",    {y0, y1, y2, y3}, 16'h0000);
      chk("t5_slot_async", 16'(slot), 16'd0);
      chk("t5_fe_async",   16'(frame_err), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(4'hC, 1'b1, 1'b1, 1'b0);
      chk("t5_fe_after", 16'(frame_err), 16'd0);
      send(4'hD, 1'b0, 1'b1, 1'b0);
      send(4'hE, 1'b0, 1'b1, 1'b0);
      send(4'hF, 1'b0, 1'b1, 1'b0);
      chk("t5_y",  {y0, y1, y2, y3}, 16'hCDEF);
      chk("t5_fv", 16'(frame_valid), 16'd1);
      idle();

`ifdef DEMUX_PARITY_EN
      // 6: bad parity on slot 2 drops the frame
      send(4'h2, 1'b1, 1'b1, 1'b0);
      send(4'h4, 1'b0, 1'b1, 1'b0);
      send(4'h6, 1'b0, 1'b1, 1'b1);
      chk("t6_fe",   16'(frame_err), 16'd1);
      chk("t6_slot", 16'(slot), 16'd0);
      send(4'h8, 1'b0, 1'b1, 1'b0);
      chk("t6_fv_none", 16'(frame_valid), 16'd0);
      chk("t6_yhold",   {y0, y1, y2, y3}, 16'hCDEF);
      idle();
      send(4'h3, 1'b1, 1'b1, 1'b0);
      send(4'h5, 1'b0, 1'b1, 1'b0);
      send(4'h7, 1'b0, 1'b1, 1'b0);
      send(4'h9, 1'b0, 1'b1, 1'b0);
      chk("t6_y",  {y0, y1, y2, y3}, 16'h3579);
      chk("t6_fv", 16'(frame_valid), 16'd1);
      idle();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
